// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-sequence detector (Mealy FSM).
// State counts how many leading pattern bits are currently matched. Mismatch
// fallbacks are computed at elaboration with a KMP-style function, so any
// PATTERN works without hand coding.
// Optional feature: define SEQDET_MATCH_CNT_EN to build the saturating match
// counter; without it match_cnt is tied to zero.
module seq_detect_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SW = $clog2(SEQ_LEN);
    localparam logic [SW-1:0] LAST = SW'(SEQ_LEN - 1);

    // Pattern bit at position idx counted from the first bit received.
    function automatic logic pbit(input int idx);
        logic [SEQ_LEN-1:0] t;
        t = PATTERN >> (SEQ_LEN - 1 - idx);
        return t[0];
    endfunction

    // Longest suffix of (first s pattern bits + b) that is a proper prefix
    // of PATTERN. With s = SEQ_LEN-1 and b = last pattern bit this yields the
    // longest proper border, i.e. the resume state for overlapping mode.
    function automatic logic [SW-1:0] kmp_next(input int s, input logic b);
        int   best;
        int   j;
        logic ok;
        logic cb;
        best = 0;
        for (int k = 1; k < SEQ_LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    j  = s + 1 - k + i;
                    cb = (j == s) ? b : pbit(j);
                    if (cb != pbit(i)) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return SW'(best);
    endfunction

    localparam logic [SW-1:0] OVL_STATE = kmp_next(SEQ_LEN - 1, PATTERN[0]);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          state_ok;
    logic [SW-1:0] nxt0 [SEQ_LEN];
    logic [SW-1:0] nxt1 [SEQ_LEN];

    // Constant transition tables, one entry per legal state and input bit.
    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_tbl
        assign nxt0[g] = kmp_next(g, 1'b0);
        assign nxt1[g] = kmp_next(g, 1'b1);
    end

    // Encodings at or above SEQ_LEN are illegal and recover to state 0.
    if ((2 ** SW) == SEQ_LEN) begin : g_full_enc
        assign state_ok = 1'b1;
    end else begin : g_part_enc
        assign state_ok = (state_q < SW'(SEQ_LEN));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= '0;
        else      state_q <= state_d;
    end

    // Next state: clear wins, gaps hold, matches resume per overlap mode.
    always_comb begin
        state_d = state_q;
        if (clr || !state_ok) begin
            state_d = '0;
        end else if (in_valid) begin
            if (out)     state_d = overlap ? OVL_STATE : '0;
            else if (in) state_d = nxt1[state_q];
            else         state_d = nxt0[state_q];
        end
    end

    // Mealy match flag: last pattern bit presented on a qualified cycle.
    always_comb begin
        out = 1'b0;
        if (rst && !clr && in_valid && state_q == LAST && in == PATTERN[0])
            out = 1'b1;
    end

    // Registered copy of the match flag (out is already 0 under clr).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_q <= 1'b0;
        else      out_q <= out;
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating match count, zeroed by clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)                      cnt_d = '0;
        else if (out && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: instance A uses the defaults (1101, CNT_W=8),
// instance B uses SEQ_LEN=8, PATTERN=A5, CNT_W=2. Expected outputs come from
// a history-window reference model plus constant vectors.
module tb_seq_detect_param;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_clr, a_valid, a_in, a_ovl, a_out, a_out_q;
    logic [7:0] a_cnt;
    logic       b_clr, b_valid, b_in, b_ovl, b_out, b_out_q;
    logic [1:0] b_cnt;

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in(a_in),
        .overlap(a_ovl), .out(a_out), .out_q(a_out_q), .match_cnt(a_cnt)
    );

    seq_detect_param #(.SEQ_LEN(8), .PATTERN(8'hA5), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_valid), .in(b_in),
        .overlap(b_ovl), .out(b_out), .out_q(b_out_q), .match_cnt(b_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] a_hist = '0, b_hist = '0;
    int          a_n = 0, b_n = 0, a_mc = 0, b_mc = 0;
    logic        a_seen, b_seen;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // A match happens when at least len bits were accepted since the last
    // restart and the newest len bits equal the pattern.
    function automatic logic tail_match(input logic [15:0] hist, input int n, input logic b,
                                        input int len, input logic [15:0] pat);
        logic [15:0] t;
        logic [15:0] m;
        t = {hist[14:0], b};
        m = 16'hFFFF >> (16 - len);
        return (n + 1 >= len) && ((t & m) == pat);
    endfunction

    task automatic mdl_upd(inout logic [15:0] h, inout int n, inout int mc,
                           input logic v, input logic b, input logic o, input logic c,
                           input logic m, input int mx);
        if (c) begin
            n  = 0;
            mc = 0;
        end else if (v) begin
            h = {h[14:0], b};
            n = (n < 16) ? n + 1 : 16;
            if (m) begin
                mc = (mc < mx) ? mc + 1 : mc;
                if (!o) n = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic av, input logic ab, input logic ao, input logic ac,
                        input logic bv, input logic bb, input logic bo, input logic bc);
        logic ea, eb;
        @(negedge clk);
        a_valid = av; a_in = ab; a_ovl = ao; a_clr = ac;
        b_valid = bv; b_in = bb; b_ovl = bo; b_clr = bc;
        ea = av && !ac && tail_match(a_hist, a_n, ab, 4, 16'h000D);
        eb = bv && !bc && tail_match(b_hist, b_n, bb, 8, 16'h00A5);
        #1;
        a_seen = a_out;
        b_seen = b_out;
        check("a_out", a_out, ea);
        check("b_out", b_out, eb);
        @(posedge clk);
        #1;
        check("a_out_q", a_out_q, ea);
        check("b_out_q", b_out_q, eb);
        mdl_upd(a_hist, a_n, a_mc, av, ab, ao, ac, ea, 255);
        mdl_upd(b_hist, b_n, b_mc, bv, bb, bo, bc, eb, 3);
        check("a_cnt", a_cnt, CNT_EN ? a_mc : 0);
        check("b_cnt", b_cnt, CNT_EN ? b_mc : 0);
    endtask

    task automatic a_step(input logic v, input logic b, input logic o, input logic c);
        step(v, b, o, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b1; a_in = 1'b1; b_valid = 1'b1; b_in = 1'b1;
        a_clr = 1'b0; b_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("rst_a_out", a_out, 0);
            check("rst_a_out_q", a_out_q, 0);
            check("rst_a_cnt", a_cnt, 0);
            check("rst_b_out", b_out, 0);
            check("rst_b_out_q", b_out_q, 0);
            check("rst_b_cnt", b_cnt, 0);
            if (k == 0) @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        a_hist = '0; b_hist = '0;
        a_n = 0; b_n = 0; a_mc = 0; b_mc = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic v;
        logic b;
        logic o;
        logic c;
        logic e;
        logic chk;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_seq(input logic [15:0] bits, input int len, input logic o,
                                    input logic [15:0] hits);
        for (int i = len - 1; i >= 0; i--)
            tbl.push_back('{v: 1'b1, b: bits[i], o: o, c: 1'b0, e: hits[i], chk: 1'b0, cnt: 0});
    endfunction

    function automatic void add_clr();
        tbl.push_back('{v: 1'b1, b: 1'b1, o: 1'b0, c: 1'b1, e: 1'b0, chk: 1'b0, cnt: 0});
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic       bq[$];
        logic [7:0] byte_v;
        logic [7:0] pat_b;
        int         hits;
        logic       av, ab, ao, ac, bv, bb, bo, bc;

        rst = 1'b1;
        a_clr = 1'b0; a_valid = 1'b0; a_in = 1'b0; a_ovl = 1'b0;
        b_clr = 1'b0; b_valid = 1'b0; b_in = 1'b0; b_ovl = 1'b0;
        #2;
        do_reset();

        // Constant vectors for the documented single-pattern cases.
        add_seq(16'b1101101, 7, 1'b0, 16'b0001000);
        add_clr();
        add_seq(16'b1101101, 7, 1'b1, 16'b0001001);
        tbl[tbl.size() - 1].chk = 1'b1;
        tbl[tbl.size() - 1].cnt = CNT_EN ? 2 : 0;
        add_clr();
        add_seq(16'b111101, 6, 1'b0, 16'b000001);
        add_clr();
        add_seq(16'b11001101, 8, 1'b1, 16'b00000001);
        add_clr();

        foreach (tbl[i]) begin
            a_step(tbl[i].v, tbl[i].b, tbl[i].o, tbl[i].c);
            check("tbl_out", a_seen, tbl[i].e);
            if (tbl[i].chk) check("tbl_cnt", a_cnt, tbl[i].cnt);
        end

        // Gap: invalid cycles with a toggling input are transparent.
        a_step(1, 1, 0, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            a_step(0, 1'($urandom_range(0, 1)), 0, 0);
            check("gap_out", a_seen, 0);
        end
        a_step(1, 1, 0, 0);
        check("gap_hit", a_seen, 1);

        // Reset mid-sequence discards partial progress.
        a_step(1, 1, 0, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 0, 0, 0);
        do_reset();
        a_step(1, 1, 0, 0);
        check("rst_nomatch", a_seen, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 0, 0, 0);
        a_step(1, 1, 0, 0);
        check("rst_match", a_seen, 1);

        // Clear mid-sequence, applied while a valid bit is present.
        a_step(1, 1, 0, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 0, 0, 0);
        a_step(1, 1, 0, 1);
        check("clr_out", a_seen, 0);
        a_step(1, 1, 0, 0);
        check("clr_nomatch", a_seen, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 1, 0, 0);
        a_step(1, 0, 0, 0);
        a_step(1, 1, 0, 0);
        check("clr_match", a_seen, 1);
        check("clr_cnt", a_cnt, CNT_EN ? 1 : 0);

        // Saturation on the 8-bit instance: five A5 bytes, overlap on.
        step(0, 0, 0, 0, 1, 0, 1, 1);
        pat_b = 8'hA5;
        hits  = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 7; i >= 0; i--) begin
                step(0, 0, 0, 0, 1, pat_b[i], 1, 0);
                if (b_seen === 1'b1) hits++;
            end
            check("sat_cnt", b_cnt, CNT_EN ? ((k < 3) ? k + 1 : 3) : 0);
        end
        check("sat_hits", hits, 5);

        // Random traffic on both instances against the reference model.
        for (int k = 0; k < 600; k++) begin
            av = ($urandom_range(0, 3) != 0);
            ab = 1'($urandom_range(0, 1));
            ao = 1'($urandom_range(0, 1));
            ac = ($urandom_range(0, 49) == 0);
            if (bq.size() == 0) begin
                byte_v = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'($urandom);
                for (int i = 7; i >= 0; i--) bq.push_back(byte_v[i]);
            end
            bv = ($urandom_range(0, 4) != 0);
            bc = ($urandom_range(0, 99) == 0);
            bo = ($urandom_range(0, 3) != 0);
            if (bv) bb = bq.pop_front();
            else    bb = 1'($urandom_range(0, 1));
            step(av, ab, ao, ac, bv, bb, bo, bc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
